// File: rtl/set_bit_iter.sv
// set_bit_iter
//   Takes a WIDTH-bit word and walks its set bits lowest index first,
//   presenting one index per output handshake. A zero word produces a
//   single beat that is flagged with out_zero.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   word offered
//   in_ready   block is idle and can take a word
//   in_data    word to scan (sampled only on the accept cycle)
//   out_valid  index beat presented
//   out_ready  consumer takes the beat
//   out_idx    index of the lowest remaining set bit
//   out_last   current beat is the final one for this word
//   out_zero   loaded word had no set bits
//   out_count  popcount of the loaded word (present with SBI_COUNT_EN)
//
// Build option
//   SBI_COUNT_EN  adds the out_count port and its popcount register.
//
// All out_* signals are decoded from registers only (state, rem, zero_flag),
// so they change only at clock edges, except when reset forces the FSM idle.

module set_bit_iter #(
  parameter int  WIDTH = 64,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic             out_zero
`ifdef SBI_COUNT_EN
  ,
  output logic [IW:0]      out_count
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic             zero_flag;

  logic [WIDTH-1:0] rem_less;
  logic [IW-1:0]    low_idx;
  logic             one_left;

  // Clearing the lowest set bit: x & (x-1).
  assign rem_less = rem & (rem - ONE);
  // Exactly one bit left when rem is nonzero and clearing it leaves nothing.
  assign one_left = (rem != '0) && (rem_less == '0);

  // Priority encoder: scanning downward leaves the lowest set index.
  // Yields 0 when rem is empty (idle, or a zero word).
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rem[i]) low_idx = IW'(i);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_idx   = low_idx;
  assign out_last  = out_valid && (zero_flag || one_left);
  assign out_zero  = out_valid && zero_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem       <= in_data;
            zero_flag <= (in_data == '0);
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            rem <= rem_less;
            if (out_last) begin
              zero_flag <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SBI_COUNT_EN
  function automatic logic [IW:0] popcount(input logic [WIDTH-1:0] w);
    logic [IW:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + (IW+1)'(w[i]);
    end
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_count <= '0;
    end else if (in_valid && in_ready) begin
      out_count <= popcount(in_data);
    end
  end
`endif

endmodule

// File: tb/tb_set_bit_iter.sv
// Testbench for set_bit_iter: stimulus pushes the expected beat list of each
// accepted word into a scoreboard queue; a monitor pops and compares on every
// output handshake. Expected beats come from a plain bit scan of the word.

module tb_set_bit_iter;

  localparam int W  = 64;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_zero;
`ifdef SBI_COUNT_EN
  logic [IW:0]   out_count;
`endif

  set_bit_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_zero  (out_zero)
`ifdef SBI_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit last;
    bit zero;
  } beat_t;

  beat_t q[$];
  int    total = 0;
  int    bad = 0;
  int    beats_seen = 0;
  int    mode = 0;      // 0: ready high, 1: random ready, 2: stall 3 cycles per beat
  int    stall_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: every set bit in ascending order, last flag on the highest;
  // a zero word is a single flagged beat at index 0.
  task automatic push_expected(input logic [W-1:0] w);
    beat_t b;
    int    hi;
    hi = -1;
    for (int i = 0; i < W; i++) if (w[i]) hi = i;
    if (hi < 0) begin
      b.idx = 0; b.last = 1'b1; b.zero = 1'b1;
      q.push_back(b);
    end else begin
      for (int i = 0; i < W; i++) begin
        if (w[i]) begin
          b.idx = i; b.last = (i == hi); b.zero = 1'b0;
          q.push_back(b);
        end
      end
    end
  endtask

  function automatic int ones(input logic [W-1:0] w);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) c += int'(w[i]);
    return c;
  endfunction

  // out_ready driver
  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && stall_cnt < 3) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else if (out_valid) begin
          out_ready = 1'b1;
          stall_cnt = 0;
        end else begin
          out_ready = 1'b0;
          stall_cnt = 0;
        end
      end
    endcase
  end

  // Monitor / scoreboard
  bit            prev_stall = 1'b0;
  bit            exp_idle = 1'b0;
  logic [IW-1:0] prev_idx;
  logic          prev_last, prev_zero;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      exp_idle   = 1'b0;
    end else begin
      chk("ready_vs_valid", {63'd0, in_ready}, {63'd0, ~out_valid});
      if (exp_idle) begin
        chk("idle_after_last", {63'd0, in_ready}, 64'd1);
        exp_idle = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_idx", {58'd0, out_idx}, {58'd0, prev_idx});
        chk("stall_last", {63'd0, out_last}, {63'd0, prev_last});
        chk("stall_zero", {63'd0, out_zero}, {63'd0, prev_zero});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", {58'd0, out_idx}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_idx", {58'd0, out_idx}, 64'(e.idx));
          chk("beat_last", {63'd0, out_last}, {63'd0, e.last});
          chk("beat_zero", {63'd0, out_zero}, {63'd0, e.zero});
        end
        beats_seen++;
        if (out_last) exp_idle = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_idx   = out_idx;
      prev_last  = out_last;
      prev_zero  = out_zero;
    end
  end

  task automatic send(input logic [W-1:0] w);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    push_expected(w);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    @(negedge clk);
    chk("load_latency", {63'd0, out_valid}, 64'd1);
`ifdef SBI_COUNT_EN
    chk("out_count", {57'd0, out_count}, 64'(ones(w)));
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] w;
    int           n, base;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_idx", {58'd0, out_idx}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
`ifdef SBI_COUNT_EN
    chk("rst_out_count", {57'd0, out_count}, 64'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    mode = 0;
    send(64'd0);                      drain();
    send(64'h8000_0000_0000_0001);    drain();
    send(64'hFFFF_FFFF_FFFF_FFFF);    drain();
    mode = 2;
    send(64'h0000_0000_0000_00A4);    drain();
    mode = 0;
    send(64'h0000_0000_0000_F0F0);    drain();

    // Reset in the middle of a word
    base = beats_seen;
    send(64'hFF00);
    n = 0;
    while (beats_seen < base + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_idx", {58'd0, out_idx}, 64'd0);
    base = beats_seen;
    send(64'h10);
    drain();
    chk("post_rst_beats", 64'(beats_seen - base), 64'd1);

    mode = 1;
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: w = '0;
        1: w = {$urandom, $urandom};
        2: w = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: w = 64'd1 << $urandom_range(0, 63);
      endcase
      send(w);
    end
    drain();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
